// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, handler address
// and the SR/Cause field positions used by cp0_unit.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LO      = 10;
    localparam int SR_IM_HI      = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_BD_BIT  = 31;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0 in the MEM stage: SR/Cause/EPC/PRId, interrupt and exception
// entry, mtc0/mfc0 access and the eret return address.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2019
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCIn,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic [4:0]  RAddr,
    input  logic [4:0]  WAddr,
    input  logic [31:0] WData,
    input  logic        WE,
    input  logic        EXLClr,
    output logic [31:0] RData,
    output logic [31:0] EPCOut,
    output logic        Interrupt
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_aligned;
    logic [31:0] entry_epc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req   = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req   = (ExcCodeIn != EXC_INT) & ~sr_exl;
    assign Interrupt = int_req | exc_req;

    // A delay-slot instruction returns to its branch so the branch re-executes.
    assign pc_aligned = word_align(PCIn);
    assign entry_epc  = BDIn ? (pc_aligned - 32'd4) : pc_aligned;

    always_comb begin
        sr_word = '0;
        sr_word[SR_IM_HI:SR_IM_LO] = sr_im;
        sr_word[SR_EXL_BIT]        = sr_exl;
        sr_word[SR_IE_BIT]         = sr_ie;
    end

    always_comb begin
        cause_word = '0;
        cause_word[CAUSE_BD_BIT]               = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]    = cause_ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO]  = cause_exc;
    end

    always_comb begin
        case (RAddr)
            REG_SR:    RData = sr_word;
            REG_CAUSE: RData = cause_word;
            REG_EPC:   RData = epc;
            REG_PRID:  RData = PRID_VALUE;
            default:   RData = '0;
        endcase
    end

    // Bypass lets an eret directly behind an mtc0 EPC use the new address.
    assign EPCOut = (WE && (WAddr == REG_EPC)) ? word_align(WData) : epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (Interrupt) begin
                // Entry drops any concurrent mtc0; the instruction re-executes after eret.
                sr_exl    <= 1'b1;
                cause_bd  <= BDIn;
                cause_exc <= int_req ? EXC_INT : ExcCodeIn;
                epc       <= entry_epc;
            end else begin
                if (WE && (WAddr == REG_SR)) begin
                    sr_im  <= WData[SR_IM_HI:SR_IM_LO];
                    sr_exl <= WData[SR_EXL_BIT];
                    sr_ie  <= WData[SR_IE_BIT];
                end
                if (WE && (WAddr == REG_EPC)) begin
                    epc <= word_align(WData);
                end
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios plus random traffic, checked against
// a field-level reference model through an expected-value queue.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h0000_2019;

    logic        clk;
    logic        reset;
    logic [31:0] PCIn;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic [4:0]  RAddr;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic        WE;
    logic        EXLClr;
    logic [31:0] RData;
    logic [31:0] EPCOut;
    logic        Interrupt;

    cp0_unit #(.PRID_VALUE(PRID)) dut (
        .clk(clk), .reset(reset), .PCIn(PCIn), .BDIn(BDIn),
        .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .RAddr(RAddr), .WAddr(WAddr),
        .WData(WData), .WE(WE), .EXLClr(EXLClr), .RData(RData),
        .EPCOut(EPCOut), .Interrupt(Interrupt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: architectural fields
    int unsigned m_im, m_ie, m_exl, m_bd, m_ip, m_exc;
    logic [31:0] m_epc;
    bit          m_valid = 0;

    logic [64:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic step(input logic rst, input logic [5:0] hw, input logic [4:0] exc,
                        input logic [31:0] pc, input logic bd, input logic [4:0] ra,
                        input logic [4:0] wa, input logic [31:0] wd, input logic we,
                        input logic ec);
        bit          int_r, exc_r, take;
        logic [31:0] e_rdata, e_epcout, pc_al;
        reset = rst; HWInt = hw; ExcCodeIn = exc; PCIn = pc; BDIn = bd;
        RAddr = ra; WAddr = wa; WData = wd; WE = we; EXLClr = ec;
        if (m_valid) begin
            int_r = ((int'(hw) & m_im) != 0) && (m_ie == 1) && (m_exl == 0);
            exc_r = (exc != 0) && (m_exl == 0);
            take  = int_r || exc_r;
            case (ra)
                5'd12:   e_rdata = m_im * 1024 + m_exl * 2 + m_ie;
                5'd13:   e_rdata = m_bd * 32'h8000_0000 + m_ip * 1024 + m_exc * 4;
                5'd14:   e_rdata = m_epc;
                5'd15:   e_rdata = PRID;
                default: e_rdata = 0;
            endcase
            e_epcout = (we && wa == 14) ? (wd & ~32'd3) : m_epc;
            exp_q.push_back({take, e_rdata, e_epcout});
            pc_al = pc & ~32'd3;
            if (rst) begin
                m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ip = 0; m_exc = 0; m_epc = 0;
            end else begin
                m_ip = hw;
                if (take) begin
                    m_exl = 1;
                    m_bd  = bd;
                    m_exc = int_r ? 0 : exc;
                    m_epc = bd ? pc_al - 4 : pc_al;
                end else begin
                    if (we && wa == 12) begin
                        m_im  = (wd / 1024) % 64;
                        m_exl = wd[1];
                        m_ie  = wd[0];
                    end
                    if (we && wa == 14) m_epc = wd & ~32'd3;
                    if (ec) m_exl = 0;
                end
            end
        end else if (rst) begin
            m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ip = 0; m_exc = 0; m_epc = 0;
            m_valid = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] ra, input logic [5:0] hw);
        step(0, hw, 0, 32'h0000_3000, 0, ra, 0, 0, 0, 0);
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
        step(0, 0, 0, 32'h0000_3000, 0, ra, wa, wd, 1, 0);
    endtask

    task automatic eret(input logic [5:0] hw);
        step(0, hw, 0, 32'h0000_3000, 0, 5'd12, 0, 0, 0, 1);
    endtask

    // scoreboard monitor
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [64:0] e;
            e = exp_q.pop_front();
            chk("Interrupt", {31'd0, Interrupt}, {31'd0, e[64]});
            chk("RData", RData, e[63:32]);
            chk("EPCOut", EPCOut, e[31:0]);
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 5'd12, 0, 0, 0, 0);
        // reset state
        rd(5'd12, 0); rd(5'd13, 0); rd(5'd14, 0); rd(5'd15, 0); rd(5'd20, 0);
        // interrupt entry
        mtc0(5'd12, 32'h0000_FC01, 5'd12);
        step(0, 6'b000001, 0, 32'h0000_3010, 0, 5'd12, 0, 0, 0, 0);
        rd(5'd14, 6'b000001); rd(5'd13, 0); rd(5'd12, 0);
        eret(0);
        // delay-slot exception
        step(0, 0, 5'd12, 32'h0000_3024, 1, 5'd13, 0, 0, 0, 0);
        rd(5'd14, 0); rd(5'd13, 0);
        step(0, 0, 5'd10, 32'h0000_3030, 0, 5'd13, 0, 0, 0, 0);
        eret(0);
        // priority
        step(0, 6'b000100, 5'd10, 32'h0000_3100, 0, 5'd13, 0, 0, 0, 0);
        rd(5'd13, 0); rd(5'd14, 0);
        eret(0);
        // masking
        mtc0(5'd12, 32'h0000_FC00, 5'd12);
        rd(5'd13, 6'b111111); rd(5'd13, 6'b010101);
        mtc0(5'd12, 32'h0000_0001, 5'd12);
        rd(5'd13, 6'b111111);
        // entry drops a concurrent mtc0 and misaligned PC is word aligned
        mtc0(5'd12, 32'h0000_FC01, 5'd12);
        step(0, 6'b100000, 0, 32'h0000_3203, 0, 5'd14, 5'd12, 32'h0, 1, 0);
        rd(5'd12, 0); rd(5'd14, 0);
        // write/return with bypass, then eret with pending interrupt
        mtc0(5'd14, 32'h0000_3047, 5'd14);
        rd(5'd14, 0);
        eret(6'b000010);
        rd(5'd12, 6'b000010);
        // mtc0 SR together with eret, then reset mid-entry
        step(0, 0, 0, 32'h0, 0, 5'd12, 5'd12, 32'h0000_0C03, 1, 1);
        rd(5'd12, 0);
        step(1, 6'b000100, 5'd4, 32'h0000_3300, 1, 5'd12, 0, 0, 0, 0);
        rd(5'd12, 0); rd(5'd13, 0); rd(5'd14, 0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [5:0]  hw;
            logic [4:0]  exc, ra, wa;
            logic [31:0] wd;
            hw  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            case ($urandom_range(0, 9))
                0: exc = 5'd4;  1: exc = 5'd5;  2: exc = 5'd10;
                3: exc = 5'd12; 4: exc = 5'($urandom);
                default: exc = 5'd0;
            endcase
            ra = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            wa = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) wd[1] = 1'b0;
            step($urandom_range(0, 99) == 0, hw, exc, $urandom, 1'($urandom),
                 ra, wa, wd, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
